a51_session_ctrl: RTL
=====================

# a51_session_ctrl

Sequencer for one A5/1 encrypt/decrypt session. It clears the three A5/1 registers and feeds them the 64 key bits and then the 22 frame bits. It then commands the 100 majority-clocked mixing cycles and captures 128 keystream bits. Finally it XORs the keystream with the 128-bit message and drains the result as 32 nibbles over a valid/ready handshake to the LCD/hex path. It replaces the switch-edge and stage-counter glue between the key/data stores, the A5/1 keygen datapath and the LCD writer.

## Interface
Parameters:
- KEY_BITS, 64, key bits loaded in the key stage
- FRAME_BITS, 22, frame bits loaded in the frame stage
- MIX_CYCLES, 100, majority-clocked cycles with output discarded
- OUT_BITS, 128, keystream bits captured; must be a multiple of 4

Ports:
- clk  in  1  single clock, all state on rising edge
- clrn  in  1  asynchronous active-low reset
- start  in  1  begin session; sampled only in IDLE
- abort  in  1  cancel session from any state
- key_in  in  KEY_BITS  key, sampled during LOAD_KEY
- frame_in  in  FRAME_BITS  frame number
- frame_load  in  1  with A51_FRAME_AUTOINC_EN: load frame_in at start
- data_in  in  OUT_BITS  message or ciphertext, sampled during DRAIN
- ks_bit_in  in  1  A5/1 output bit (R1[18]^R2[21]^R3[22])
- lfsr_clr  out  1  synchronous clear of the A5/1 registers
- lfsr_load_en  out  1  clock all three registers regardless of majority
- lfsr_load_bit  out  1  bit XORed into every register's feedback
- lfsr_mix_en  out  1  clock registers under majority rule
- nib_data  out  4  XORed output nibble
- nib_valid  out  1  nib_data valid
- nib_ready  in  1  consumer accepts nibble
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last nibble transfers

## Operation
- States: IDLE, CLEAR, LOAD_KEY, LOAD_FRAME, MIX, GEN, DRAIN. One shared 8-bit cycle counter is zeroed on every state entry.
- IDLE, start=1, abort=0: go to CLEAR. start is ignored in every other state.
- CLEAR (1 cycle): lfsr_clr=1, then go to LOAD_KEY.
- LOAD_KEY (KEY_BITS cycles): lfsr_load_en=1, lfsr_load_bit=key_in[cnt]. key_in[0] goes first.
- LOAD_FRAME (FRAME_BITS cycles): lfsr_load_en=1, lfsr_load_bit=frame[cnt]. frame[0] goes first.
- MIX (MIX_CYCLES cycles): lfsr_mix_en=1, lfsr_load_bit=0.
- GEN (OUT_BITS cycles): lfsr_mix_en=1. ks_bit_in is registered into ks[cnt] each cycle, before that cycle's clocking.
- DRAIN: nib_valid=1, nib_data = ks[4k+3:4k] ^ data_in[4k+3:4k], with k = nibble index 0..OUT_BITS/4-1.
  - k advances on nib_valid & nib_ready.
  - After the transfer with k = OUT_BITS/4-1: pulse done and go to IDLE.
- abort=1 in any state: go to IDLE next cycle.
  - lfsr_clr=1 for that cycle when leaving a non-IDLE state.
  - No done pulse; ks contents become don't-care.
  - abort takes priority over start and over handshake completion in the same cycle.
- lfsr_load_en and lfsr_mix_en are never both high. Both are low in IDLE, CLEAR and DRAIN.
- Reset values: every output 0, state IDLE, counters 0, ks 0.
- Reset asserted mid-session: same as power-on; the session is not resumed.

## Timing
- Control outputs are registered state decodes. lfsr_load_bit is a combinational mux of registered state, counter and key_in/frame.
- start is sampled at edge E0, then:
  - CLEAR occupies cycle 1.
  - LOAD_KEY occupies cycles 2..65.
  - LOAD_FRAME occupies cycles 66..87.
  - MIX occupies cycles 88..187.
  - GEN occupies cycles 188..315.
  - nib_valid first rises in cycle 316.
- With nib_ready tied high: one nibble per cycle; done is high in cycle 348, and IDLE is reached in cycle 348.
- nib_ready low: nib_data and k hold, and nib_valid stays high. There is no timeout.
- busy rises the cycle after start is sampled and falls the cycle done is high.
- Back-to-back: a start held high during the done cycle is sampled in IDLE one cycle later.

## Configuration
- A51_FRAME_AUTOINC_EN defined:
  - Holds an internal FRAME_BITS frame register.
  - A start with frame_load=1 loads frame_in into the register.
  - A start with frame_load=0 uses the stored value.
  - The register increments modulo 2^FRAME_BITS on each done pulse; 0x3FFFFF wraps to 0. abort does not increment it.
  - Reset value 0.
- A51_FRAME_AUTOINC_EN undefined: frame_in is used directly in LOAD_FRAME, frame_load is ignored, and no frame register exists.

## Test plan
- Key 0x EFCDAB8967452312, frame 0x134, data 0, ready high:
  - The 32 nibbles must equal the golden-model A5/1 keystream bits 0..127 in nibble order.
  - done must occur in cycle 348.
- Same key and frame with data 0x0123456789ABCDEF_FEDCBA9876543210: each nibble must equal the keystream nibble XOR the data nibble.
  - A second pass feeding that ciphertext as data_in must return the original data.
- nib_ready toggled 1,0,0,1 repeatedly: no nibble is lost or duplicated; nib_data is stable while stalled; exactly 32 transfers, then one done pulse.
- abort in cycle 100 (MIX), and separately in DRAIN after 5 transfers:
  - IDLE next cycle, lfsr_clr pulse, no done.
  - A new start yields the full correct stream.
- start=1 and abort=1 together in IDLE: stays IDLE, busy stays 0. start pulsed during GEN is ignored.
- A51_FRAME_AUTOINC_EN: start with frame_load=1 and frame_in=0x3FFFFF, then two starts with frame_load=0.
  - The second and third sessions must match golden streams for frames 0x000000 and 0x000001.
  - clrn pulsed mid-session returns all outputs to 0.

Source files
------------

// File: rtl/a51_session_ctrl.sv
// Session sequencer for one A5/1 run: clear, load key and frame, mix, capture keystream, XOR-drain nibbles.
// Define A51_FRAME_AUTOINC_EN to keep an internal frame register that advances after every completed session.
module a51_session_ctrl #(
  parameter int KEY_BITS   = 64,
  parameter int FRAME_BITS = 22,
  parameter int MIX_CYCLES = 100,
  parameter int OUT_BITS   = 128
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [KEY_BITS-1:0]   key_in,
  input  logic [FRAME_BITS-1:0] frame_in,
  input  logic                  frame_load,
  input  logic [OUT_BITS-1:0]   data_in,
  input  logic                  ks_bit_in,
  output logic                  lfsr_clr,
  output logic                  lfsr_load_en,
  output logic                  lfsr_load_bit,
  output logic                  lfsr_mix_en,
  output logic [3:0]            nib_data,
  output logic                  nib_valid,
  input  logic                  nib_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int NIBBLES = OUT_BITS / 4;
  localparam int KW      = $clog2(KEY_BITS);
  localparam int FW      = $clog2(FRAME_BITS);
  localparam int OW      = $clog2(OUT_BITS);
  localparam int NW      = $clog2(NIBBLES);

  localparam logic [7:0] KEY_LAST   = 8'(KEY_BITS - 1);
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_BITS - 1);
  localparam logic [7:0] MIX_LAST   = 8'(MIX_CYCLES - 1);
  localparam logic [7:0] OUT_LAST   = 8'(OUT_BITS - 1);
  localparam logic [7:0] NIB_LAST   = 8'(NIBBLES - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD_KEY, LOAD_FRAME, MIX, GEN, DRAIN
  } state_t;

  state_t                state;
  logic [7:0]            cnt;
  logic [OUT_BITS-1:0]   ks;
  logic [FRAME_BITS-1:0] frame_sel;
  logic [NW+1:0]         nib_base;

`ifdef A51_FRAME_AUTOINC_EN
  logic [FRAME_BITS-1:0] frame_reg;

  // Stored frame number: loaded on request at start, advanced only by a completed session.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame_reg <= '0;
    end else if (!abort && state == IDLE && start && frame_load) begin
      frame_reg <= frame_in;
    end else if (!abort && state == DRAIN && nib_ready && cnt == NIB_LAST) begin
      frame_reg <= frame_reg + FRAME_BITS'(1);
    end
  end

  assign frame_sel = frame_reg;
`else
  logic unused_frame_load;
  assign unused_frame_load = frame_load;
  assign frame_sel         = frame_in;
`endif

  always_comb begin
    lfsr_load_bit = 1'b0;
    case (state)
      LOAD_KEY:   lfsr_load_bit = key_in[cnt[KW-1:0]];
      LOAD_FRAME: lfsr_load_bit = frame_sel[cnt[FW-1:0]];
      default:    lfsr_load_bit = 1'b0;
    endcase
  end

  assign nib_base = {cnt[NW-1:0], 2'b00};
  assign nib_data = nib_valid ? (ks[nib_base +: 4] ^ data_in[nib_base +: 4]) : 4'h0;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state        <= IDLE;
      cnt          <= '0;
      ks           <= '0;
      lfsr_clr     <= 1'b0;
      lfsr_load_en <= 1'b0;
      lfsr_mix_en  <= 1'b0;
      nib_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      lfsr_clr <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        // Leaving a live session wipes the A5/1 registers so no key state lingers.
        lfsr_clr     <= (state != IDLE);
        state        <= IDLE;
        cnt          <= '0;
        lfsr_load_en <= 1'b0;
        lfsr_mix_en  <= 1'b0;
        nib_valid    <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= CLEAR;
              cnt      <= '0;
              lfsr_clr <= 1'b1;
              busy     <= 1'b1;
            end
          end
          CLEAR: begin
            state        <= LOAD_KEY;
            cnt          <= '0;
            lfsr_load_en <= 1'b1;
          end
          LOAD_KEY: begin
            if (cnt == KEY_LAST) begin
              state <= LOAD_FRAME;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          LOAD_FRAME: begin
            if (cnt == FRAME_LAST) begin
              state        <= MIX;
              cnt          <= '0;
              lfsr_load_en <= 1'b0;
              lfsr_mix_en  <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          MIX: begin
            if (cnt == MIX_LAST) begin
              state <= GEN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          GEN: begin
            // The output bit seen this cycle reflects the registers before this cycle's clock.
            ks[cnt[OW-1:0]] <= ks_bit_in;
            if (cnt == OUT_LAST) begin
              state       <= DRAIN;
              cnt         <= '0;
              lfsr_mix_en <= 1'b0;
              nib_valid   <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          DRAIN: begin
            if (nib_ready) begin
              if (cnt == NIB_LAST) begin
                state     <= IDLE;
                cnt       <= '0;
                nib_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
